mul_job_sequencer: RTL

Bus-master sequencer that sits directly upstream of the 24x24 multiply/popcount GPIO peripheral. It accepts operand pairs from a valid/ready job port and buffers them in a small FIFO. For each job it drives the peripheral's register bus (write A, write B, start, poll status, read W, read L) and presents the product and popcount on a valid/ready result port. It replaces hand-coded CPU register sequences with a self-timed hardware job queue.

---
 rtl/mul_job_sequencer_if.sv | 18 +
 rtl/mul_job_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_job_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_job_sequencer_if
// Brief    : Register bus between the job sequencer and the multiply/popcount
//            GPIO peripheral.
// Revision : 1.0 - initial release
// ============================================================================
interface mul_job_sequencer_if;
    logic [15:0] saddress;
    logic        swr;
    logic        srd;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (output saddress, output swr, output srd, output bus_wdata, input bus_rdata);
    modport slave  (input saddress, input swr, input srd, input bus_wdata, output bus_rdata);
endinterface
`default_nettype wire

// File: rtl/mul_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul_job_sequencer
// Brief    : FIFO-fed bus master that runs multiply/popcount jobs on the GPIO
//            peripheral and returns product and popcount on a result port.
// Revision : 1.0 - initial release
// ============================================================================
module mul_job_sequencer #(
    parameter int DEPTH      = 4,
    parameter int POLL_LIMIT = 64
) (
    input  wire                  clk,
    input  wire                  n_reset,
    input  wire                  job_valid,
    output logic                 job_ready,
    input  wire  [23:0]          job_a,
    input  wire  [23:0]          job_b,
    output logic                 res_valid,
    input  wire                  res_ready,
    output logic [31:0]          res_w,
    output logic [5:0]           res_l,
    output logic                 res_timeout,
    mul_job_sequencer_if.master  bus,
    output logic                 busy,
    output logic [15:0]          jobs_done
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PCW = $clog2(POLL_LIMIT + 1);
    localparam logic [PCW-1:0] c_poll_last = PCW'(POLL_LIMIT - 1);
    localparam logic [15:0]    c_addr_a    = 16'h0380;
    localparam logic [15:0]    c_addr_b    = 16'h0388;
    localparam logic [15:0]    c_addr_w    = 16'h0390;
    localparam logic [15:0]    c_addr_l    = 16'h0398;
    localparam logic [15:0]    c_addr_go   = 16'h03A0;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_WR_A  = 4'd1,
        S_WR_B  = 4'd2,
        S_WR_GO = 4'd3,
        S_POLL  = 4'd4,
        S_RD_W  = 4'd5,
        S_RD_L  = 4'd6,
        S_OUT   = 4'd7
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP  = 2'd0,
        PH_STROBE = 2'd1,
        PH_HOLD   = 2'd2
    } phase_t;

    state_t          r_state;
    phase_t          r_phase;
    logic [23:0]     r_a;
    logic [23:0]     r_b;
    logic [PCW-1:0]  r_poll_cnt;
    logic [15:0]     r_saddress;
    logic            r_swr;
    logic            r_srd;
    logic [31:0]     r_wdata;
    logic            r_res_valid;
    logic [31:0]     r_res_w;
    logic [5:0]      r_res_l;
    logic            r_res_timeout;
    logic [15:0]     r_jobs_done;

    logic [47:0]     r_mem [DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [47:0]     w_head;
    logic            w_is_write;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push     = job_valid && !w_full;
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_is_write = (r_state == S_WR_A) || (r_state == S_WR_B) || (r_state == S_WR_GO);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {job_a, job_b};
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state       <= S_IDLE;
            r_phase       <= PH_SETUP;
            r_a           <= '0;
            r_b           <= '0;
            r_poll_cnt    <= '0;
            r_saddress    <= '0;
            r_swr         <= 1'b0;
            r_srd         <= 1'b0;
            r_wdata       <= '0;
            r_res_valid   <= 1'b0;
            r_res_w       <= '0;
            r_res_l       <= '0;
            r_res_timeout <= 1'b0;
            r_jobs_done   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_a           <= w_head[47:24];
                        r_b           <= w_head[23:0];
                        r_poll_cnt    <= '0;
                        r_res_timeout <= 1'b0;
                        r_state       <= S_WR_A;
                        r_phase       <= PH_SETUP;
                        r_saddress    <= c_addr_a;
                        r_wdata       <= {8'h00, w_head[47:24]};
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_jobs_done <= r_jobs_done + 16'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    case (r_phase)
                        PH_SETUP: begin
                            r_phase <= PH_STROBE;
                            r_swr   <= w_is_write;
                            r_srd   <= !w_is_write;
                        end
                        PH_STROBE: begin
                            r_phase <= PH_HOLD;
                            r_swr   <= 1'b0;
                            r_srd   <= 1'b0;
                        end
                        default: begin
                            // End of HOLD: launch the next access's SETUP or leave the bus idle.
                            r_phase    <= PH_SETUP;
                            r_saddress <= '0;
                            r_wdata    <= '0;
                            case (r_state)
                                S_WR_A: begin
                                    r_state    <= S_WR_B;
                                    r_saddress <= c_addr_b;
                                    r_wdata    <= {8'h00, r_b};
                                end
                                S_WR_B: begin
                                    r_state    <= S_WR_GO;
                                    r_saddress <= c_addr_go;
                                    r_wdata    <= 32'h1;
                                end
                                S_WR_GO: begin
                                    r_state    <= S_POLL;
                                    r_saddress <= c_addr_go;
                                end
                                S_POLL: begin
                                    if (bus.bus_rdata[1]) begin
                                        r_state    <= S_RD_W;
                                        r_saddress <= c_addr_w;
                                    end else if (r_poll_cnt == c_poll_last) begin
                                        r_poll_cnt    <= r_poll_cnt + PCW'(1);
                                        r_res_timeout <= 1'b1;
                                        r_res_w       <= '0;
                                        r_res_l       <= '0;
                                        r_res_valid   <= 1'b1;
                                        r_state       <= S_OUT;
                                    end else begin
                                        r_poll_cnt <= r_poll_cnt + PCW'(1);
                                        r_saddress <= c_addr_go;
                                    end
                                end
                                S_RD_W: begin
                                    r_res_w    <= bus.bus_rdata;
                                    r_state    <= S_RD_L;
                                    r_saddress <= c_addr_l;
                                end
                                S_RD_L: begin
                                    r_res_l     <= bus.bus_rdata[5:0];
                                    r_res_valid <= 1'b1;
                                    r_state     <= S_OUT;
                                end
                                default: r_state <= S_IDLE;
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

    assign job_ready     = !w_full;
    assign busy          = (r_state != S_IDLE) || !w_empty;
    assign res_valid     = r_res_valid;
    assign res_w         = r_res_w;
    assign res_l         = r_res_l;
    assign res_timeout   = r_res_timeout;
    assign jobs_done     = r_jobs_done;
    assign bus.saddress  = r_saddress;
    assign bus.swr       = r_swr;
    assign bus.srd       = r_srd;
    assign bus.bus_wdata = r_wdata;
endmodule
`default_nettype wire
